// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the memory-port arbiter.
//   owner_t   : which requester a read belongs to (fetch or load/store)
//   rd_tag_t  : one tag-pipe entry, {valid, owner}
//   TAG_NONE  : empty tag pushed on cycles that issue no read
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int MAX_READ_LATENCY = 4;
   localparam int STREAK_W         = 4;

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } rd_tag_t;

   localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_F};

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
//   Shift register of read tags, READ_LATENCY entries deep. A tag pushed in
//   the cycle a read is issued reaches the tail exactly when the memory
//   returns that read's data, so ownership follows issue order for free.
//   Ports:
//     clk, reset : clock and asynchronous active-high reset
//     push       : tag for the command issued this cycle (TAG_NONE if none)
//     tail       : tag matching the read data returned this cycle
// -----------------------------------------------------------------------------
module rd_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t push,
   output rd_tag_t tail
);

   rd_tag_t stage [READ_LATENCY];

   // NOTE: every stage is reset, not only the data path around it: a stale
   // valid bit surviving reset would emit a return nobody asked for.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            stage[i] <= TAG_NONE;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value, giving a true shift regardless of order.
         stage[0] <= push;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tail = stage[READ_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (F) and load/store (D).
//   One grant per cycle, D has priority, but F cannot be passed over more
//   than MAX_STREAK times in a row. Reads are tagged so each requester sees
//   only its own data, READ_LATENCY cycles after issue.
//   Ports:
//     clk, reset                        : clock, async active-high reset
//     i_f_req/i_f_addr                  : fetch read request
//     o_f_gnt, o_f_rdvalid/o_f_rddata   : fetch grant and read return
//     i_d_rd/i_d_wr/i_d_addr/i_d_wrdata : load/store request
//     o_d_gnt, o_d_rdvalid/o_d_rddata   : load/store grant and read return
//     o_mem_addr/rd/wr/wrdata           : memory command (zero when idle)
//     i_mem_rddata                      : memory read data
//     o_err                             : sticky, D asked to read and write
//                                         in the same cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1,
   parameter int MAX_STREAK   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_f_req,
   input  logic [ADDR_W-1:0] i_f_addr,
   output logic              o_f_gnt,
   output logic              o_f_rdvalid,
   output logic [DATA_W-1:0] o_f_rddata,
   input  logic              i_d_rd,
   input  logic              i_d_wr,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [DATA_W-1:0] i_d_wrdata,
   output logic              o_d_gnt,
   output logic              o_d_rdvalid,
   output logic [DATA_W-1:0] o_d_rddata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   output logic              o_mem_wr,
   output logic [DATA_W-1:0] o_mem_wrdata,
   input  logic [DATA_W-1:0] i_mem_rddata,
   output logic              o_err
);

   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("mem_port_arbiter: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
   end
   if (MAX_STREAK < 1 || MAX_STREAK > (2**STREAK_W) - 1) begin : g_bad_streak
      $error("mem_port_arbiter: MAX_STREAK must be 1..%0d", (2**STREAK_W) - 1);
   end

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic                d_req;
   logic                d_gnt;
   logic                f_gnt;
   logic [STREAK_W-1:0] streak;   // D grants in a row while F was waiting
   rd_tag_t             push_tag;
   rd_tag_t             tail_tag;

   assign d_req = i_d_rd | i_d_wr;

   // Arbitration. Grants are forced low during reset so the memory never
   // sees a strobe while the tag pipe is being cleared.
   // NOTE: both grants get a default before any branch, so no path through
   // the block leaves them unassigned and no latch is inferred.
   always_comb begin
      d_gnt = 1'b0;
      f_gnt = 1'b0;
      if (!reset) begin
         if (d_req && (!i_f_req || streak < STREAK_MAX)) begin
            d_gnt = 1'b1;
         end else if (i_f_req) begin
            f_gnt = 1'b1;
         end
      end
   end

   assign o_f_gnt = f_gnt;
   assign o_d_gnt = d_gnt;

   // Starvation guard: counts D wins that F had to watch. Any cycle where
   // F is idle or served resets the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak <= '0;
      end else if (f_gnt || !i_f_req) begin
         streak <= '0;
      end else if (d_gnt && streak != STREAK_MAX) begin
         streak <= streak + STREAK_W'(1);
      end
   end

   // Sticky protocol error: a simultaneous read+write is served as a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_err <= 1'b0;
      end else if (i_d_rd && i_d_wr) begin
         o_err <= 1'b1;
      end
   end

   // Memory command mux; every field is zero unless a grant drives it.
   always_comb begin
      o_mem_addr   = '0;
      o_mem_rd     = 1'b0;
      o_mem_wr     = 1'b0;
      o_mem_wrdata = '0;
      if (d_gnt) begin
         o_mem_addr = i_d_addr;
         if (i_d_wr) begin
            o_mem_wr     = 1'b1;
            o_mem_wrdata = i_d_wrdata;
         end else begin
            o_mem_rd = 1'b1;
         end
      end else if (f_gnt) begin
         o_mem_addr = i_f_addr;
         o_mem_rd   = 1'b1;
      end
   end

   // Every issued read leaves a tag; writes and idle cycles push an empty one.
   always_comb begin
      push_tag       = TAG_NONE;
      push_tag.valid = o_mem_rd;
      push_tag.owner = d_gnt ? OWN_D : OWN_F;
   end

   rd_tag_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .push  (push_tag),
      .tail  (tail_tag)
   );

   // Route returning data to its owner only; the other side sees zeros.
   assign o_f_rdvalid = tail_tag.valid && (tail_tag.owner == OWN_F);
   assign o_d_rdvalid = tail_tag.valid && (tail_tag.owner == OWN_D);
   assign o_f_rddata  = o_f_rdvalid ? i_mem_rddata : '0;
   assign o_d_rddata  = o_d_rdvalid ? i_mem_rddata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Three arbiters (READ_LATENCY 1, 2, 3) share one stimulus stream; each has
// its own latency-matched memory and is compared against a queue-based model.
module tb_mem_port_arbiter;

   localparam int MAX_STREAK = 4;
   localparam int N_INST     = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        f_req, d_rd, d_wr;
   logic [15:0] f_addr, d_addr, d_wrdata;

   logic        f_gnt [N_INST];
   logic        d_gnt [N_INST];
   logic        f_rdvalid [N_INST];
   logic        d_rdvalid [N_INST];
   logic        mem_rd [N_INST];
   logic        mem_wr [N_INST];
   logic        err [N_INST];
   logic [15:0] f_rddata [N_INST];
   logic [15:0] d_rddata [N_INST];
   logic [15:0] mem_addr [N_INST];
   logic [15:0] mem_wrdata [N_INST];
   logic [15:0] mem_rddata [N_INST];

   // Read-only memory image, word addressed by addr[8:1].
   logic [15:0] mem_img [256];

   for (genvar g = 0; g < N_INST; g++) begin : g_inst
      localparam int LAT = g + 1;
      logic [16:0] line [LAT];
      logic [15:0] garbage;

      mem_port_arbiter #(
         .ADDR_W       (16),
         .DATA_W       (16),
         .READ_LATENCY (LAT),
         .MAX_STREAK   (MAX_STREAK)
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .i_f_req      (f_req),
         .i_f_addr     (f_addr),
         .o_f_gnt      (f_gnt[g]),
         .o_f_rdvalid  (f_rdvalid[g]),
         .o_f_rddata   (f_rddata[g]),
         .i_d_rd       (d_rd),
         .i_d_wr       (d_wr),
         .i_d_addr     (d_addr),
         .i_d_wrdata   (d_wrdata),
         .o_d_gnt      (d_gnt[g]),
         .o_d_rdvalid  (d_rdvalid[g]),
         .o_d_rddata   (d_rddata[g]),
         .o_mem_addr   (mem_addr[g]),
         .o_mem_rd     (mem_rd[g]),
         .o_mem_wr     (mem_wr[g]),
         .o_mem_wrdata (mem_wrdata[g]),
         .i_mem_rddata (mem_rddata[g]),
         .o_err        (err[g])
      );

      // Memory: returns the addressed word LAT cycles after a read strobe,
      // random junk on every other cycle.
      always @(posedge clk) begin
         line[0] <= {mem_rd[g], mem_addr[g]};
         for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
         garbage <= 16'($urandom);
      end
      assign mem_rddata[g] = line[LAT-1][16] ? mem_img[line[LAT-1][8:1]] : garbage;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          due;
      logic        owner_d;
      logic [15:0] addr;
   } exp_rd_t;

   exp_rd_t rq [N_INST][$];
   int   cyc        = 0;
   int   m_run      = 0;      // D wins in a row that F has had to watch
   logic m_err      = 1'b0;
   logic f_gnt_seen = 1'b0;
   logic d_gnt_seen = 1'b0;

   always @(negedge clk) begin
      logic        eg_f, eg_d, e_rd, e_wr;
      logic [15:0] e_addr, e_wrdata;
      logic        ef_v, ed_v;
      logic [15:0] ef_d, ed_d;
      exp_rd_t     r;
      cyc++;
      if (reset) begin
         for (int k = 0; k < N_INST; k++) begin
            check($sformatf("rst_ctrl[%0d]", k),
                  {f_gnt[k], d_gnt[k], f_rdvalid[k], d_rdvalid[k], mem_rd[k], mem_wr[k], err[k]}, '0);
            check($sformatf("rst_data[%0d]", k),
                  {f_rddata[k], d_rddata[k], mem_addr[k], mem_wrdata[k]}, '0);
            rq[k].delete();
         end
         m_run = 0; m_err = 1'b0; f_gnt_seen = 1'b0; d_gnt_seen = 1'b0;
      end else begin
         eg_d     = (d_rd || d_wr) && (!f_req || m_run < MAX_STREAK);
         eg_f     = !eg_d && f_req;
         e_wr     = eg_d && d_wr;
         e_rd     = eg_f || (eg_d && !d_wr);
         e_addr   = eg_d ? d_addr : (eg_f ? f_addr : 16'h0);
         e_wrdata = e_wr ? d_wrdata : 16'h0;
         for (int k = 0; k < N_INST; k++) begin
            ef_v = 1'b0; ed_v = 1'b0; ef_d = 16'h0; ed_d = 16'h0;
            if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
               r = rq[k].pop_front();
               if (r.owner_d) begin ed_v = 1'b1; ed_d = mem_img[r.addr[8:1]]; end
               else           begin ef_v = 1'b1; ef_d = mem_img[r.addr[8:1]]; end
            end
            check($sformatf("gnt[%0d]", k), {f_gnt[k], d_gnt[k]}, {eg_f, eg_d});
            check($sformatf("cmd[%0d]", k), {mem_rd[k], mem_wr[k], mem_addr[k], mem_wrdata[k]},
                  {e_rd, e_wr, e_addr, e_wrdata});
            check($sformatf("f_ret[%0d]", k), {f_rdvalid[k], f_rddata[k]}, {ef_v, ef_d});
            check($sformatf("d_ret[%0d]", k), {d_rdvalid[k], d_rddata[k]}, {ed_v, ed_d});
            check($sformatf("err[%0d]", k), err[k], m_err);
            if (e_rd) rq[k].push_back('{due: cyc + k + 1, owner_d: eg_d, addr: e_addr});
         end
         if (d_rd && d_wr) m_err = 1'b1;
         if (eg_f || !f_req) m_run = 0;
         else if (eg_d && m_run < MAX_STREAK) m_run++;
         f_gnt_seen = eg_f;
         d_gnt_seen = eg_d;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      f_req = 1'b0; f_addr = 16'h0;
      d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wrdata = 16'h0;
   endtask

   initial begin
      logic [9:0] pat;
      logic       seen;
      int         r;
      for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
      idle();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      // Quiet after reset
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_quiet", {f_gnt[0], d_gnt[0], mem_rd[0], mem_wr[0], f_rdvalid[0], d_rdvalid[0], err[0]}, '0);
         tick();
      end

      // F-only stream, LAT=1
      mem_img[8'h00] = 16'h1111; mem_img[8'h01] = 16'h2222;
      mem_img[8'h02] = 16'h3333; mem_img[8'h80] = 16'hBEEF;
      f_req = 1'b1; f_addr = 16'h0000;
      @(negedge clk); check("fs_issue0", {f_gnt[0], mem_rd[0], mem_addr[0]}, {1'b1, 1'b1, 16'h0000}); tick();
      f_addr = 16'h0002;
      @(negedge clk); check("fs_issue1", {f_gnt[0], mem_addr[0]}, {1'b1, 16'h0002});
                      check("fs_ret0", {f_rdvalid[0], f_rddata[0]}, {1'b1, 16'h1111}); tick();
      f_addr = 16'h0004;
      @(negedge clk); check("fs_ret1", {f_rdvalid[0], f_rddata[0]}, {1'b1, 16'h2222}); tick();
      idle();
      @(negedge clk); check("fs_ret2", {f_rdvalid[0], f_rddata[0]}, {1'b1, 16'h3333});
                      check("fs_no_d", d_rdvalid[0], 1'b0); tick();

      // Simultaneous F and D read: D first, data routed to owner
      f_req = 1'b1; f_addr = 16'h0004; d_rd = 1'b1; d_addr = 16'h0100;
      @(negedge clk); check("sim_d_first", {f_gnt[0], d_gnt[0]}, 2'b01); tick();
      d_rd = 1'b0; d_addr = 16'h0;
      @(negedge clk); check("sim_f_next", {f_gnt[0], d_gnt[0]}, 2'b10);
                      check("sim_d_data", {d_rdvalid[0], d_rddata[0], f_rdvalid[0]}, {1'b1, 16'hBEEF, 1'b0}); tick();
      idle();
      @(negedge clk); check("sim_f_data", {f_rdvalid[0], f_rddata[0], d_rdvalid[0]}, {1'b1, 16'h3333, 1'b0}); tick();

      // Starvation bound: D held, F always waiting
      f_req = 1'b1; f_addr = 16'h0006; d_rd = 1'b1; d_addr = 16'h0008;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pat[i] = d_gnt[0];
         tick();
         if (f_gnt_seen) f_addr = f_addr + 16'h2;
      end
      check("streak_pattern", pat, 10'b0111101111);

      // Write: command in grant cycle, wrdata zero on next fetch
      idle(); d_wr = 1'b1; d_addr = 16'h0040; d_wrdata = 16'h1234;
      @(negedge clk); check("wr_cmd", {mem_wr[0], mem_rd[0], mem_addr[0], mem_wrdata[0]},
                            {1'b1, 1'b0, 16'h0040, 16'h1234}); tick();
      idle(); f_req = 1'b1; f_addr = 16'h0000;
      @(negedge clk); check("wr_then_f", {mem_rd[0], mem_wr[0], mem_wrdata[0]}, {1'b1, 1'b0, 16'h0000}); tick();
      idle();
      repeat (4) tick();

      // Reset while a LAT=2 read is in flight
      f_req = 1'b1; f_addr = 16'h0002;
      @(negedge clk); tick();
      idle(); reset = 1'b1;
      @(negedge clk); tick();
      reset = 1'b0; seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); seen = seen | f_rdvalid[1] | d_rdvalid[1]; tick();
      end
      check("rst_drops_read", seen, 1'b0);

      // Interleaved D then F, checked on LAT=2 and LAT=3
      f_req = 1'b1; f_addr = 16'h0000; d_rd = 1'b1; d_addr = 16'h0100;
      @(negedge clk); check("il_d_gnt", d_gnt[2], 1'b1); tick();
      d_rd = 1'b0; d_addr = 16'h0;
      @(negedge clk); check("il_f_gnt", f_gnt[2], 1'b1); tick();
      idle();
      @(negedge clk); check("il2_d_ret", {d_rdvalid[1], d_rddata[1]}, {1'b1, 16'hBEEF}); tick();
      @(negedge clk); check("il3_d_ret", {d_rdvalid[2], d_rddata[2], f_rdvalid[2]}, {1'b1, 16'hBEEF, 1'b0}); tick();
      @(negedge clk); check("il3_f_ret", {f_rdvalid[2], f_rddata[2], d_rdvalid[2]}, {1'b1, 16'h1111, 1'b0}); tick();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(99) == 0);
         if (!f_req || f_gnt_seen || $urandom_range(15) == 0) begin
            f_req  = ($urandom_range(99) < 60);
            f_addr = 16'($urandom);
         end
         if (!(d_rd || d_wr) || d_gnt_seen || $urandom_range(15) == 0) begin
            r        = $urandom_range(9);
            d_rd     = (r >= 4 && r <= 7);
            d_wr     = (r >= 8);
            d_addr   = 16'($urandom);
            d_wrdata = 16'($urandom);
         end
         tick();
      end
      reset = 1'b0; idle();
      repeat (4) tick();

      // Read+write together: served as write, sticky error
      d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0050; d_wrdata = 16'hAAAA;
      @(negedge clk); check("err_cycle", {err[0], mem_wr[0], mem_rd[0], mem_wrdata[0]},
                            {1'b0, 1'b1, 1'b0, 16'hAAAA}); tick();
      idle();
      @(negedge clk); check("err_set", err[0], 1'b1); tick();
      repeat (3) tick();
      @(negedge clk); check("err_sticky", {err[0], err[1], err[2]}, 3'b111); tick();
      reset = 1'b1;
      @(negedge clk); check("err_rst", err[0], 1'b0); tick();
      reset = 1'b0;
      @(negedge clk); check("err_after_rst", err[0], 1'b0); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
